// File: rtl/pzcorebus_write_data_gate_if.sv
// Signal bundle for the write-data gate: upstream command/data ports and downstream command/data ports.
// A transfer happens on a channel in any cycle where its valid and its accept are both high. Valid never waits on accept.
interface pzcorebus_write_data_gate_if #(
  parameter int COMMAND_WIDTH   = 64,
  parameter int DATA_WIDTH      = 128,
  parameter int LENGTH_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 4
);
  logic                                 i_mcmd_valid;
  logic                                 o_scmd_accept;
  logic [COMMAND_WIDTH-1:0]             i_mcmd;
  logic                                 i_mcmd_write;
  logic [LENGTH_WIDTH-1:0]              i_mcmd_length;
  logic                                 o_mcmd_valid;
  logic                                 i_scmd_accept;
  logic [COMMAND_WIDTH-1:0]             o_mcmd;
  logic                                 i_mdata_valid;
  logic                                 o_sdata_accept;
  logic [DATA_WIDTH-1:0]                i_mdata;
  logic                                 i_mdata_last;
  logic                                 o_mdata_valid;
  logic                                 i_sdata_accept;
  logic [DATA_WIDTH-1:0]                o_mdata;
  logic                                 o_mdata_last;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding;
  logic                                 o_length_error;

  modport slave (
    input  i_mcmd_valid, i_mcmd, i_mcmd_write, i_mcmd_length, i_scmd_accept,
    input  i_mdata_valid, i_mdata, i_mdata_last, i_sdata_accept,
    output o_scmd_accept, o_mcmd_valid, o_mcmd,
    output o_sdata_accept, o_mdata_valid, o_mdata, o_mdata_last,
    output o_outstanding, o_length_error
  );

  modport master (
    output i_mcmd_valid, i_mcmd, i_mcmd_write, i_mcmd_length, i_scmd_accept,
    output i_mdata_valid, i_mdata, i_mdata_last, i_sdata_accept,
    input  o_scmd_accept, o_mcmd_valid, o_mcmd,
    input  o_sdata_accept, o_mdata_valid, o_mdata, o_mdata_last,
    input  o_outstanding, o_length_error
  );
endinterface

// File: rtl/pzcorebus_write_data_gate.sv
// Holds write data back until its command has gone downstream, limits bursts in flight by a credit count,
// and regenerates the last-beat flag from the command length (the upstream last flag is only checked).
module pzcorebus_write_data_gate #(
  parameter int COMMAND_WIDTH   = 64,
  parameter int DATA_WIDTH      = 128,
  parameter int LENGTH_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                        i_clk,
  input logic                        i_rst,
  pzcorebus_write_data_gate_if.slave bus
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [OW-1:0]           outstanding;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [LENGTH_WIDTH-1:0] beat;
  logic [LENGTH_WIDTH-1:0] len_mem [MAX_OUTSTANDING];
  logic                    length_error;

  logic full;
  logic empty;
  logic cmd_block;
  logic push;
  logic data_hs;
  logic last;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Both flags come from registers only, so data can never pass in its own command's cycle.
  assign full      = (outstanding == OW'(MAX_OUTSTANDING));
  assign empty     = (outstanding == '0);
  assign cmd_block = bus.i_mcmd_write && full;

  assign bus.o_mcmd         = bus.i_mcmd;
  assign bus.o_mcmd_valid   = bus.i_mcmd_valid && !cmd_block;
  assign bus.o_scmd_accept  = bus.i_scmd_accept && !cmd_block;

  assign bus.o_mdata        = bus.i_mdata;
  assign bus.o_mdata_valid  = bus.i_mdata_valid && !empty;
  assign bus.o_sdata_accept = bus.i_sdata_accept && !empty;

  assign last    = !empty && (beat == len_mem[rd_ptr]);
  assign push    = bus.o_mcmd_valid && bus.i_scmd_accept && bus.i_mcmd_write;
  assign data_hs = bus.o_mdata_valid && bus.i_sdata_accept;
  assign pop     = data_hs && last;

  assign bus.o_mdata_last   = last;
  assign bus.o_outstanding  = outstanding;
  assign bus.o_length_error = length_error;

  always_ff @(posedge i_clk) begin
    if (push) begin
      len_mem[wr_ptr] <= bus.i_mcmd_length;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outstanding  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      beat         <= '0;
      length_error <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        outstanding <= outstanding + OW'(1);
      end else if (pop && !push) begin
        outstanding <= outstanding - OW'(1);
      end
      if (data_hs) begin
        beat <= last ? '0 : beat + LENGTH_WIDTH'(1);
        if (bus.i_mdata_last != last) begin
          length_error <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pzcorebus_write_data_gate.sv
// Bench for pzcorebus_write_data_gate: a table of hand-computed per-cycle vectors, then a long
// randomized run against a master-side burst tracker.
module tb_pzcorebus_write_data_gate;
  localparam int CW = 64;
  localparam int DW = 128;
  localparam int LW = 4;
  localparam int MO = 4;

  typedef struct {
    logic          rst;
    logic          mv;
    logic          mw;
    logic [LW-1:0] ml;
    logic          sa;
    logic          dv;
    logic          dl;
    logic          da;
    logic          e_mv;
    logic          e_sa;
    logic          e_dv;
    logic          e_da;
    logic          e_last;
    logic [2:0]    e_out;
    logic          e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pzcorebus_write_data_gate_if #(
    .COMMAND_WIDTH(CW), .DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .MAX_OUTSTANDING(MO)
  ) bus ();

  pzcorebus_write_data_gate #(
    .COMMAND_WIDTH(CW), .DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  logic [LW-1:0] exp_q[$];
  logic [CW-1:0] cmd_word;
  logic [DW-1:0] data_word;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (vector %0d)", name, act, exp, n_vec);
    end
  endtask

  task automatic add(input bit r, input bit mv, input bit mw, input int ml, input bit sa,
                     input bit dv, input bit dl, input bit da,
                     input bit e_mv, input bit e_sa, input bit e_dv, input bit e_da,
                     input bit e_last, input int e_out, input bit e_err);
    vec_t v;
    v.rst = r; v.mv = mv; v.mw = mw; v.ml = LW'(ml); v.sa = sa;
    v.dv = dv; v.dl = dl; v.da = da;
    v.e_mv = e_mv; v.e_sa = e_sa; v.e_dv = e_dv; v.e_da = e_da;
    v.e_last = e_last; v.e_out = 3'(e_out); v.e_err = e_err;
    tbl.push_back(v);
  endtask

  // driver tasks
  task automatic drive(input logic mv, input logic mw, input logic [LW-1:0] ml, input logic sa,
                       input logic dv, input logic dl, input logic da);
    cmd_word  = {$urandom, $urandom};
    data_word = {$urandom, $urandom, $urandom, $urandom};
    bus.i_mcmd_valid   = mv;
    bus.i_mcmd_write   = mw;
    bus.i_mcmd_length  = ml;
    bus.i_mcmd         = cmd_word;
    bus.i_scmd_accept  = sa;
    bus.i_mdata_valid  = dv;
    bus.i_mdata_last   = dl;
    bus.i_mdata        = data_word;
    bus.i_sdata_accept = da;
  endtask

  task automatic check_pass;
    chk("mcmd_pass", bus.o_mcmd, cmd_word);
    chk("mdata_pass", bus.o_mdata, data_word);
  endtask

  task automatic fill_table;
    // rst mv mw ml sa  dv dl da  | e_mv e_sa e_dv e_da e_last e_out e_err
    add(1,0,0,0,1, 1,0,1, 0,1,0,0,0,0,0);
    add(1,0,0,0,1, 1,0,1, 0,1,0,0,0,0,0);
    // length 3 with data in the command cycle
    add(0,1,1,3,1, 1,0,1, 1,1,0,0,0,0,0);
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,1,0);
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,1,0);
    add(0,0,0,0,1, 1,0,0, 0,1,1,0,0,1,0);
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,1,0);
    add(0,0,0,0,1, 1,1,1, 0,1,1,1,1,1,0);
    add(0,0,0,0,1, 1,0,1, 0,1,0,0,0,0,0);
    // fill credits with data stalled, then a blocked write and a passing read
    add(0,1,1,0,1, 0,0,0, 1,1,0,0,0,0,0);
    add(0,1,1,1,1, 0,0,0, 1,1,0,0,1,1,0);
    add(0,1,1,0,1, 0,0,0, 1,1,0,0,1,2,0);
    add(0,1,1,1,1, 0,0,0, 1,1,0,0,1,3,0);
    add(0,1,1,2,1, 0,0,0, 0,0,0,0,1,4,0);
    add(0,1,0,2,1, 0,0,0, 1,1,0,0,1,4,0);
    add(0,1,1,2,1, 1,1,1, 0,0,1,1,1,4,0);
    add(0,1,1,2,1, 1,0,1, 1,1,1,1,0,3,0);
    add(0,0,0,0,1, 1,1,1, 0,1,1,1,1,4,0);
    add(0,0,0,0,1, 1,1,1, 0,1,1,1,1,3,0);
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,2,0);
    add(0,0,0,0,1, 1,1,1, 0,1,1,1,1,2,0);
    // burst end and new write command in the same cycle
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,1,0);
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,1,0);
    add(0,1,1,1,1, 1,1,1, 1,1,1,1,1,1,0);
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,1,0);
    add(0,0,0,0,1, 1,1,1, 0,1,1,1,1,1,0);
    add(0,0,0,0,1, 1,0,1, 0,1,0,0,0,0,0);
    // early upstream last flag sets the sticky error
    add(0,1,1,2,1, 0,0,0, 1,1,0,0,0,0,0);
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,1,0);
    add(0,0,0,0,1, 1,1,1, 0,1,1,1,0,1,0);
    add(0,0,0,0,1, 1,1,1, 0,1,1,1,1,1,1);
    add(0,0,0,0,1, 0,0,0, 0,1,0,0,0,0,1);
    add(0,0,0,0,1, 0,0,0, 0,1,0,0,0,0,1);
    // reset mid-burst
    add(0,1,1,3,1, 0,0,0, 1,1,0,0,0,0,1);
    add(0,0,0,0,1, 1,0,1, 0,1,1,1,0,1,1);
    add(1,0,0,0,1, 1,0,1, 0,1,0,0,0,0,0);
    add(0,0,0,0,1, 1,0,1, 0,1,0,0,0,0,0);
    add(0,1,1,0,1, 1,1,1, 1,1,0,0,0,0,0);
    add(0,0,0,0,1, 1,1,1, 0,1,1,1,1,1,0);
    // downstream command back-pressure: no credit taken
    add(0,1,1,5,0, 0,0,0, 1,0,0,0,0,0,0);
    add(0,0,0,0,1, 1,0,1, 0,1,0,0,0,0,0);
  endtask

  task automatic run_table;
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst;
      drive(tbl[i].mv, tbl[i].mw, tbl[i].ml, tbl[i].sa, tbl[i].dv, tbl[i].dl, tbl[i].da);
      #1;
      n_vec++;
      chk("mcmd_valid", 128'(bus.o_mcmd_valid), 128'(tbl[i].e_mv));
      chk("scmd_accept", 128'(bus.o_scmd_accept), 128'(tbl[i].e_sa));
      chk("mdata_valid", 128'(bus.o_mdata_valid), 128'(tbl[i].e_dv));
      chk("sdata_accept", 128'(bus.o_sdata_accept), 128'(tbl[i].e_da));
      chk("mdata_last", 128'(bus.o_mdata_last), 128'(tbl[i].e_last));
      chk("outstanding", 128'(bus.o_outstanding), 128'(tbl[i].e_out));
      chk("length_error", 128'(bus.o_length_error), 128'(tbl[i].e_err));
      check_pass();
    end
  endtask

  // Randomized traffic: the master side only presents beats of bursts whose command has gone.
  task automatic run_random;
    int n_tr = 0;
    int n_wr = 0;
    int n_last = 0;
    int cycles = 0;
    int beat_idx = 0;
    logic mv, mw, sa, dv, dl, da, full, exp_last;
    logic [LW-1:0] ml;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    while (n_tr < 10000 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      mv = 1'($urandom_range(0, 1));
      mw = 1'($urandom_range(0, 1));
      ml = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 3));
      sa = ($urandom_range(0, 3) != 0);
      da = ($urandom_range(0, 3) != 0);
      dv = 1'b0;
      dl = 1'b0;
      if (exp_q.size() > 0) begin
        dv = ($urandom_range(0, 3) != 0);
        dl = dv && (beat_idx == int'(exp_q[0]));
      end
      drive(mv, mw, ml, sa, dv, dl, da);
      #1;
      n_vec++;
      full = (exp_q.size() == MO);
      exp_last = (exp_q.size() > 0) && (beat_idx == int'(exp_q[0]));
      chk("rnd_mcmd_valid", 128'(bus.o_mcmd_valid), 128'(mv && !(mw && full)));
      chk("rnd_scmd_accept", 128'(bus.o_scmd_accept), 128'(sa && !(mw && full)));
      chk("rnd_mdata_valid", 128'(bus.o_mdata_valid), 128'(dv));
      chk("rnd_sdata_accept", 128'(bus.o_sdata_accept), 128'(da && exp_q.size() > 0));
      chk("rnd_mdata_last", 128'(bus.o_mdata_last), 128'(exp_last));
      chk("rnd_outstanding", 128'(bus.o_outstanding), 128'(exp_q.size()));
      chk("rnd_length_error", 128'(bus.o_length_error), 128'(0));
      if (dv && da) begin
        n_tr++;
        if (bus.o_mdata_last) n_last++;
        if (exp_last) begin
          void'(exp_q.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      if (mv && sa) n_tr++;
      if (mv && sa && mw && !full) begin
        exp_q.push_back(ml);
        n_wr++;
      end
    end
    n_vec++;
    chk("rnd_budget", 128'(n_tr >= 10000), 128'(1));
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      exp_last = (beat_idx == int'(exp_q[0]));
      drive(0, 0, '0, 1, 1, exp_last, 1);
      #1;
      if (bus.o_mdata_valid && bus.o_mdata_last) n_last++;
      if (exp_last) begin
        void'(exp_q.pop_front());
        beat_idx = 0;
      end else begin
        beat_idx++;
      end
    end
    @(negedge clk);
    drive(0, 0, '0, 1, 0, 0, 1);
    #1;
    n_vec++;
    chk("drain_budget", 128'(exp_q.size()), 128'(0));
    chk("last_count", 128'(n_last), 128'(n_wr));
    chk("drain_outstanding", 128'(bus.o_outstanding), 128'(0));
    chk("drain_length_error", 128'(bus.o_length_error), 128'(0));
  endtask

  initial begin
    drive(0, 0, '0, 0, 0, 0, 0);
    fill_table();
    run_table();
    run_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pzcorebus_write_data_gate.md
PZCOREBUS_WRITE_DATA_GATE -- requirements
Module: pzcorebus_write_data_gate

Interface
REQ-001 SHALL have parameter COMMAND_WIDTH, default 64, width of the packed command.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, width of the packed write-data beat.
REQ-003 SHALL have parameter LENGTH_WIDTH, default 4, width of the burst-length field, encoded as beats-1.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum write bursts whose command has been sent but whose data is not yet complete; legal range 2..16.
REQ-005 SHALL have ports i_clk, input, 1, clock; i_rst, input, 1, reset; one clock, reset asynchronous and active-high.
REQ-006 SHALL have ports i_mcmd_valid, input, 1; o_scmd_accept, output, 1; i_mcmd, input, COMMAND_WIDTH; i_mcmd_write, input, 1, command carries write data; i_mcmd_length, input, LENGTH_WIDTH, beats-1.
REQ-007 SHALL have ports o_mcmd_valid, output, 1; i_scmd_accept, input, 1; o_mcmd, output, COMMAND_WIDTH; these form the downstream command channel.
REQ-008 SHALL have ports i_mdata_valid, input, 1; o_sdata_accept, output, 1; i_mdata, input, DATA_WIDTH; i_mdata_last, input, 1, upstream last-beat flag.
REQ-009 SHALL have ports o_mdata_valid, output, 1; i_sdata_accept, input, 1; o_mdata, output, DATA_WIDTH; o_mdata_last, output, 1, regenerated last flag.
REQ-010 SHALL have ports o_outstanding, output, $clog2(MAX_OUTSTANDING+1), current credit count; o_length_error, output, 1, sticky length-mismatch flag.

Function
REQ-011 SHALL pass o_mcmd = i_mcmd and o_mdata = i_mdata combinationally, with no data storage.
REQ-012 SHALL drive o_mcmd_valid = i_mcmd_valid && !(i_mcmd_write && full), and o_scmd_accept = i_scmd_accept && !(i_mcmd_write && full), where full means outstanding == MAX_OUTSTANDING.
REQ-013 SHALL never block a non-write command, regardless of credit state.
REQ-014 SHALL push i_mcmd_length into an internal length FIFO of depth MAX_OUTSTANDING on every write-command handshake (o_mcmd_valid && i_scmd_accept && i_mcmd_write).
REQ-015 SHALL drive o_mdata_valid = i_mdata_valid && !empty, and o_sdata_accept = i_sdata_accept && !empty, where empty means outstanding == 0.
REQ-016 SHALL base empty/full on registered state only, so that write data is forwarded no earlier than the cycle after its command handshake (1-cycle minimum command-to-data latency).
REQ-017 SHALL keep a beat counter of LENGTH_WIDTH bits that increments on each data handshake and clears to 0 on the final beat.
REQ-018 SHALL drive o_mdata_last = (beat counter == FIFO head length) whenever !empty, and 0 when empty.
REQ-019 SHALL pop the FIFO and decrement outstanding on the data handshake where o_mdata_last = 1.
REQ-020 SHALL leave outstanding unchanged on a same-cycle push and pop, and SHALL keep the FIFO pointers wrap-correct across MAX_OUTSTANDING entries.
REQ-021 SHALL set o_length_error on any data handshake where i_mdata_last != o_mdata_last, and SHALL hold it until reset.
REQ-022 SHALL NOT use i_mdata_last to control beat counting, FIFO pop or outstanding; i_mdata_last is checked only.
REQ-023 SHALL accept a single-beat burst (length 0), whose only beat has o_mdata_last = 1.

Reset
REQ-024 SHALL, while i_rst = 1, hold outstanding = 0, FIFO pointers = 0, beat counter = 0, o_length_error = 0, and therefore o_mdata_valid = 0, o_sdata_accept = 0 and o_mdata_last = 0.
REQ-025 SHALL, when reset is asserted mid-burst, discard all in-flight burst state; the first post-reset data is blocked until a new write command handshake occurs.

Verification
REQ-026 Write cmd length 3 with data presented in the same cycle -> data blocked in the cmd cycle; 4 beats pass starting next cycle, o_mdata_last on beat 4 only; outstanding goes 0->1->0.
REQ-027 Four write cmds (MAX_OUTSTANDING=4) with data stalled -> 5th write cmd sees o_mcmd_valid=0 and o_scmd_accept=0, while a read cmd still passes; releasing one burst unblocks the 5th.
REQ-028 Burst ends and a new write cmd handshakes in the same cycle -> outstanding stays 1 and the FIFO head advances to the new length.
REQ-029 Length 2 burst with i_mdata_last asserted on beat 2 -> o_length_error=1 after that cycle and stays 1; o_mdata_last still asserts on beat 3.
REQ-030 Reset asserted after beat 1 of a length-3 burst -> all outputs return to reset values; post-reset data is blocked until a new cmd.
REQ-031 Random cmd/data/accept back-pressure, 10k transactions -> every o_mdata_last count equals the write command count, with no data ahead of its command and no length error.
